// File: rtl/instr_dispatch.sv
// instr_dispatch: initiator side of the execution-FSM start/done handshake.
//
// Takes one decoded instruction word at a time. Screens illegal operand codes,
// then sends a one-cycle opcode pulse on o_fsm_start with the latched operand
// codes and waits for i_done before retiring. NOP retires without issuing.
//
// Optional feature: define DISPATCH_TIMEOUT_EN to bound the wait for i_done to
// TIMEOUT_CYCLES cycles. On expiry the instruction faults with code 11.
//
// Ports:
//   i_clock         system clock, rising edge
//   i_reset         synchronous, active-high reset
//   i_instr_valid   instruction word available
//   o_instr_ready   dispatcher can accept (high only in IDLE)
//   i_instr         [15:12] opcode, [11:6] source, [5:0] dest
//   i_done          OR of all execution-FSM done pulses
//   o_fsm_start     opcode pulse to execution FSMs, 0 = no request
//   o_source        latched source operand code
//   o_dest          latched dest operand code
//   o_busy          instruction in flight (ISSUE or WAIT)
//   o_retire        one-cycle pulse per completed instruction
//   o_fault         one-cycle pulse per rejected or aborted instruction
//   o_fault_code    01 illegal source, 10 illegal dest, 11 timeout; sticky
//   o_retire_count  completed instructions, wraps
module instr_dispatch #(
  parameter int unsigned OPC_W          = 4,
  parameter int unsigned OPR_W          = 6,
  parameter int unsigned NUM_REGS       = 5,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_instr_valid,
  output logic                     o_instr_ready,
  input  logic [OPC_W+2*OPR_W-1:0] i_instr,
  input  logic                     i_done,
  output logic [OPC_W-1:0]         o_fsm_start,
  output logic [OPR_W-1:0]         o_source,
  output logic [OPR_W-1:0]         o_dest,
  output logic                     o_busy,
  output logic                     o_retire,
  output logic                     o_fault,
  output logic [1:0]               o_fault_code,
  output logic [CNT_W-1:0]         o_retire_count
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StRetire, StFault} state_t;

  // Code of I1, the highest legal source; also the lowest illegal dest (I1 is read-only).
  localparam logic [OPR_W-1:0] LP_I1 = OPR_W'(NUM_REGS + 1);

  state_t             r_state;
  logic [OPC_W-1:0]   r_opc;
  logic [OPC_W-1:0]   r_fsm_start;
  logic [OPR_W-1:0]   r_source;
  logic [OPR_W-1:0]   r_dest;
  logic               r_busy;
  logic               r_retire;
  logic               r_fault;
  logic [1:0]         r_fault_code;
  logic [CNT_W-1:0]   r_retire_count;

  logic [OPC_W-1:0]   w_opc;
  logic [OPR_W-1:0]   w_src;
  logic [OPR_W-1:0]   w_dst;
  logic               w_src_bad;
  logic               w_dst_bad;

  assign w_opc     = i_instr[OPC_W+2*OPR_W-1 -: OPC_W];
  assign w_src     = i_instr[2*OPR_W-1 -: OPR_W];
  assign w_dst     = i_instr[OPR_W-1:0];
  assign w_src_bad = (w_src > LP_I1);
  assign w_dst_bad = (w_dst >= LP_I1);

`ifdef DISPATCH_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_opc          <= '0;
      r_fsm_start    <= '0;
      r_source       <= '0;
      r_dest         <= '0;
      r_busy         <= 1'b0;
      r_retire       <= 1'b0;
      r_fault        <= 1'b0;
      r_fault_code   <= 2'b00;
      r_retire_count <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      r_tmo          <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_instr_valid) begin
            r_opc        <= w_opc;
            r_source     <= w_src;
            r_dest       <= w_dst;
            r_fault_code <= 2'b00;
            if (w_opc == '0) begin
              r_state        <= StRetire;
              r_retire       <= 1'b1;
              r_retire_count <= r_retire_count + CNT_W'(1);
            end else if (w_src_bad) begin
              // Source is checked first so a doubly-illegal word reports 01.
              r_state      <= StFault;
              r_fault      <= 1'b1;
              r_fault_code <= 2'b01;
            end else if (w_dst_bad) begin
              r_state      <= StFault;
              r_fault      <= 1'b1;
              r_fault_code <= 2'b10;
            end else begin
              r_state     <= StIssue;
              r_fsm_start <= w_opc;
              r_busy      <= 1'b1;
            end
          end
        end
        StIssue: begin
          // i_done is ignored here; the FSMs cannot have answered yet.
          r_state     <= StWait;
          r_fsm_start <= '0;
`ifdef DISPATCH_TIMEOUT_EN
          r_tmo       <= TMO_W'(TIMEOUT_CYCLES);
`endif
        end
        StWait: begin
          if (i_done) begin
            r_state        <= StRetire;
            r_retire       <= 1'b1;
            r_busy         <= 1'b0;
            r_retire_count <= r_retire_count + CNT_W'(1);
          end
`ifdef DISPATCH_TIMEOUT_EN
          // done in the expiry cycle takes the branch above and retires.
          else if (r_tmo == TMO_W'(1)) begin
            r_state      <= StFault;
            r_fault      <= 1'b1;
            r_busy       <= 1'b0;
            r_fault_code <= 2'b11;
          end else begin
            r_tmo <= r_tmo - TMO_W'(1);
          end
`endif
        end
        StRetire: begin
          r_state  <= StIdle;
          r_retire <= 1'b0;
        end
        StFault: begin
          r_state <= StIdle;
          r_fault <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_instr_ready  = (r_state == StIdle);
  assign o_fsm_start    = r_fsm_start;
  assign o_source       = r_source;
  assign o_dest         = r_dest;
  assign o_busy         = r_busy;
  assign o_retire       = r_retire;
  assign o_fault        = r_fault;
  assign o_fault_code   = r_fault_code;
  assign o_retire_count = r_retire_count;

  // Kept only so the opcode latch stays visible in debug; outputs use r_fsm_start.
  logic w_unused_opc;
  assign w_unused_opc = ^r_opc;

endmodule

// File: tb/tb_instr_dispatch.sv
module tb_instr_dispatch;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_instr_valid;
  logic        o_instr_ready;
  logic [15:0] i_instr;
  logic        i_done;
  logic [3:0]  o_fsm_start;
  logic [5:0]  o_source;
  logic [5:0]  o_dest;
  logic        o_busy;
  logic        o_retire;
  logic        o_fault;
  logic [1:0]  o_fault_code;
  logic [15:0] o_retire_count;

  always #5 clk = ~clk;

  instr_dispatch dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_instr_valid  (i_instr_valid),
    .o_instr_ready  (o_instr_ready),
    .i_instr        (i_instr),
    .i_done         (i_done),
    .o_fsm_start    (o_fsm_start),
    .o_source       (o_source),
    .o_dest         (o_dest),
    .o_busy         (o_busy),
    .o_retire       (o_retire),
    .o_fault        (o_fault),
    .o_fault_code   (o_fault_code),
    .o_retire_count (o_retire_count)
  );

  typedef struct {
    logic        is_fault;
    logic [1:0]  code;
    logic [15:0] count;
  } ev_t;

  typedef struct {
    logic [3:0] opc;
    logic [5:0] src;
    logic [5:0] dst;
  } iss_t;

  ev_t   evq[$];
  iss_t  issq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 1'b0;
  logic [15:0] m_count = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pops expected issue/retire/fault records as the DUT produces them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_fsm_start != 4'd0) begin
        if (issq.size() == 0) check_eq("unexpected_start", {28'd0, o_fsm_start}, 32'd0);
        else begin
          iss_t e;
          e = issq.pop_front();
          check_eq("start_opc", {28'd0, o_fsm_start}, {28'd0, e.opc});
          check_eq("start_src", {26'd0, o_source}, {26'd0, e.src});
          check_eq("start_dst", {26'd0, o_dest}, {26'd0, e.dst});
        end
      end
      if (o_retire || o_fault) begin
        if (evq.size() == 0) check_eq("unexpected_event", {30'd0, o_retire, o_fault}, 32'd0);
        else begin
          ev_t e;
          e = evq.pop_front();
          check_eq("ev_kind", {31'd0, o_fault}, {31'd0, e.is_fault});
          check_eq("ev_retire", {31'd0, o_retire}, {31'd0, ~e.is_fault});
          check_eq("ev_code", {30'd0, o_fault_code}, {30'd0, e.code});
          check_eq("ev_count", {16'd0, o_retire_count}, {16'd0, e.count});
        end
      end
    end
  end

  // Predicts the outcome of one word, then presents it for a single accepted cycle.
  // Entered and left on a falling edge; on return the DUT is in the cycle after accept.
  task automatic send(input logic [15:0] w, input bit push_ev);
    int   g;
    iss_t is;
    ev_t  ev;
    g = 0;
    while (!o_instr_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!o_instr_ready) check_eq("ready_wait", 32'd0, 32'd1);
    is.opc = w[15:12];
    is.src = w[11:6];
    is.dst = w[5:0];
    ev.is_fault = 1'b0;
    ev.code     = 2'b00;
    if (is.opc == 4'd0) begin
      m_count  = m_count + 16'd1;
      ev.count = m_count;
    end else if (is.src > 6'd6) begin
      ev.is_fault = 1'b1;
      ev.code     = 2'b01;
      ev.count    = m_count;
    end else if (is.dst > 6'd5) begin
      ev.is_fault = 1'b1;
      ev.code     = 2'b10;
      ev.count    = m_count;
    end else begin
      issq.push_back(is);
      if (push_ev) begin
        m_count  = m_count + 16'd1;
        ev.count = m_count;
      end
    end
    if (push_ev || ev.is_fault || is.opc == 4'd0) evq.push_back(ev);
    i_instr_valid = 1'b1;
    i_instr       = w;
    @(negedge clk);
    i_instr_valid = 1'b0;
  endtask

  task automatic pulse_done();
    i_done = 1'b1;
    @(negedge clk);
    i_done = 1'b0;
  endtask

  initial begin
    int  k;
    bit  all_busy;
    i_reset       = 1'b1;
    i_instr_valid = 1'b0;
    i_instr       = '0;
    i_done        = 1'b0;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    check_eq("rst_ready",  {31'd0, o_instr_ready}, 32'd1);
    check_eq("rst_busy",   {31'd0, o_busy}, 32'd0);
    check_eq("rst_start",  {28'd0, o_fsm_start}, 32'd0);
    check_eq("rst_pulses", {30'd0, o_retire, o_fault}, 32'd0);
    check_eq("rst_code",   {30'd0, o_fault_code}, 32'd0);
    check_eq("rst_count",  {16'd0, o_retire_count}, 32'd0);
    check_eq("rst_src",    {26'd0, o_source}, 32'd0);
    mon_en = 1'b1;

    // MOV r1->r3, done 4 cycles after the start pulse.
    send(16'h4043, 1'b1);
    check_eq("mov_start", {28'd0, o_fsm_start}, 32'h4);
    check_eq("mov_busy",  {31'd0, o_busy}, 32'd1);
    check_eq("mov_notready", {31'd0, o_instr_ready}, 32'd0);
    @(negedge clk);
    check_eq("mov_start_1cyc", {28'd0, o_fsm_start}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("mov_wait_busy", {31'd0, o_busy}, 32'd1);
    pulse_done();
    check_eq("mov_retire", {31'd0, o_retire}, 32'd1);
    check_eq("mov_busy_off", {31'd0, o_busy}, 32'd0);
    check_eq("mov_src_hold", {26'd0, o_source}, 32'd1);
    check_eq("mov_dst_hold", {26'd0, o_dest}, 32'd3);
    check_eq("mov_count", {16'd0, o_retire_count}, 32'd1);
    @(negedge clk);
    check_eq("mov_retire_1cyc", {31'd0, o_retire}, 32'd0);
    check_eq("mov_idle_ready", {31'd0, o_instr_ready}, 32'd1);

    // NOP retires in the cycle after accept without issuing.
    send(16'h0000, 1'b1);
    check_eq("nop_retire", {31'd0, o_retire}, 32'd1);
    check_eq("nop_start", {28'd0, o_fsm_start}, 32'd0);
    @(negedge clk);

    // Illegal dest (I1), illegal source, and both illegal.
    send(16'h4146, 1'b1);
    check_eq("dst_fault", {31'd0, o_fault}, 32'd1);
    check_eq("dst_code", {30'd0, o_fault_code}, 32'h2);
    @(negedge clk);
    check_eq("dst_code_sticky", {30'd0, o_fault_code}, 32'h2);
    check_eq("dst_fault_1cyc", {31'd0, o_fault}, 32'd0);
    send(16'h4FC1, 1'b1);
    check_eq("src_code", {30'd0, o_fault_code}, 32'h1);
    @(negedge clk);
    send(16'h4FFF, 1'b1);
    check_eq("both_code", {30'd0, o_fault_code}, 32'h1);
    @(negedge clk);

    // Boundary legal: source I1, dest r4; accept clears the sticky code.
    send(16'h1184, 1'b1);
    check_eq("legal_code_clr", {30'd0, o_fault_code}, 32'd0);
    check_eq("legal_start", {28'd0, o_fsm_start}, 32'h1);
    pulse_done();
    pulse_done();
    check_eq("legal_count", {16'd0, o_retire_count}, {16'd0, m_count});

`ifdef DISPATCH_TIMEOUT_EN
    // done in the last WAIT cycle wins over expiry.
    send(16'h4043, 1'b1);
    repeat (64) @(negedge clk);
    pulse_done();
    check_eq("tmo_done_wins", {31'd0, o_retire}, 32'd1);
    @(negedge clk);
    // No done: fault 11 after 64 WAIT cycles.
    send(16'h4043, 1'b0);
    begin
      ev_t ev;
      ev.is_fault = 1'b1;
      ev.code     = 2'b11;
      ev.count    = m_count;
      evq.push_back(ev);
    end
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (o_fault) break;
    end
    check_eq("tmo_latency", k, 32'd65);
    check_eq("tmo_code", {30'd0, o_fault_code}, 32'h3);
    @(negedge clk);
    send(16'h4043, 1'b0);
    repeat (3) @(negedge clk);
`else
    // Without the timeout, WAIT holds indefinitely.
    send(16'h4043, 1'b0);
    all_busy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!o_busy || o_fault) all_busy = 1'b0;
    end
    check_eq("no_tmo_busy", {31'd0, all_busy}, 32'd1);
`endif

    // Reset while in WAIT.
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    m_count = '0;
    check_eq("wrst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("wrst_ready", {31'd0, o_instr_ready}, 32'd1);
    check_eq("wrst_count", {16'd0, o_retire_count}, 32'd0);
    check_eq("wrst_pulses", {30'd0, o_retire, o_fault}, 32'd0);
    pulse_done();
    check_eq("late_done", {30'd0, o_retire, o_fault}, 32'd0);

    // Stray done in IDLE, then three NOPs with valid held high.
    pulse_done();
    check_eq("stray_done", {31'd0, o_retire}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      ev_t ev;
      m_count     = m_count + 16'd1;
      ev.is_fault = 1'b0;
      ev.code     = 2'b00;
      ev.count    = m_count;
      evq.push_back(ev);
    end
    i_instr       = 16'h0000;
    i_instr_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("b2b_retire_%0d", i), {31'd0, o_retire}, {31'd0, 1'(i % 2)});
      if (i == 5) i_instr_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_eq("b2b_count", {16'd0, o_retire_count}, 32'd3);

    check_eq("evq_drained", evq.size(), 32'd0);
    check_eq("issq_drained", issq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
